// File: rtl/f1_start_ctrl_if.sv
// Handshake bundle between the F1 start-light sequencer, its stimulus
// sources (divider tick, trigger/abort, LFSR value) and the lamp outputs.
interface f1_start_ctrl_if #(
  parameter int N_LIGHTS = 8,
  parameter int RND_W    = 7
);
  logic                tick;
  logic                trigger;
  logic                abort;
  logic [RND_W-1:0]    rnd;
  logic                rnd_en;
  logic [N_LIGHTS-1:0] lights;
  logic                busy;
  logic                done;

  modport master (
    output tick, trigger, abort, rnd,
    input  rnd_en, lights, busy, done
  );

  modport slave (
    input  tick, trigger, abort, rnd,
    output rnd_en, lights, busy, done
  );
endinterface

// File: rtl/f1_start_ctrl.sv
// F1 start-lights sequencer: fills the lamps one per tick, holds them for a
// random number of ticks taken from the LFSR, then clears them and pulses done.
//
// state | meaning
// IDLE  | lamps off, LFSR free-running, waiting for trigger
// FILL  | one more lamp lit per tick until all are on
// HOLD  | all lamps lit, dly counts remaining hold ticks down to 1
module f1_start_ctrl #(
  parameter int N_LIGHTS = 8,
  parameter int RND_W    = 7
) (
  input  logic            clk,
  input  logic            rst,
  f1_start_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [RND_W-1:0]    dly_q, dly_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lights_q <= '0;
      dly_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      dly_q    <= dly_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    dly_d    = dly_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        lights_d = '0;
        if (bus.trigger) state_d = FILL;
      end
      FILL: begin
        if (bus.abort) begin
          lights_d = '0;
          state_d  = IDLE;
        end else if (bus.tick) begin
          lights_d = {lights_q[N_LIGHTS-2:0], 1'b1};
          if (&lights_d) begin
            // A zero LFSR value would otherwise mean a 2^RND_W tick hold.
            dly_d   = (bus.rnd == '0) ? RND_W'(1) : bus.rnd;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.abort) begin
          lights_d = '0;
          state_d  = IDLE;
        end else if (bus.tick) begin
          if (dly_q == RND_W'(1)) begin
            lights_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            dly_d = dly_q - RND_W'(1);
          end
        end
      end
      default: begin
        lights_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  assign bus.lights = lights_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.rnd_en = (state_q == IDLE);

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Directed bench for the F1 start-light sequencer; expected lamp/busy/done
// values are queued as each cycle is driven and compared after the edge.
module tb_f1_start_ctrl;
  localparam int NL = 8;
  localparam int RW = 7;

  typedef struct {
    logic [NL-1:0] lights;
    logic          busy;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc_n   = 0;
  exp_t sb[$];

  f1_start_ctrl_if #(.N_LIGHTS(NL), .RND_W(RW)) bus ();

  f1_start_ctrl #(.N_LIGHTS(NL), .RND_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check.
  task automatic cyc(input logic t, input logic tr, input logic ab, input logic [RW-1:0] r,
                     input logic [NL-1:0] el, input logic eb, input logic ed);
    exp_t e;
    bus.tick    = t;
    bus.trigger = tr;
    bus.abort   = ab;
    bus.rnd     = r;
    e.lights = el;
    e.busy   = eb;
    e.done   = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc_n++;
    e = sb.pop_front();
    chk("lights", 32'(bus.lights), 32'(e.lights));
    chk("busy",   32'(bus.busy),   32'(e.busy));
    chk("done",   32'(bus.done),   32'(e.done));
    chk("rnd_en", 32'(bus.rnd_en), 32'(!e.busy));
  endtask

  function automatic logic [NL-1:0] fill(input int j);
    logic [NL-1:0] v;
    v = '0;
    for (int i = 0; i < j; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Starting in FILL with no lamps lit, apply NL ticks; rnd = rv on the last one.
  task automatic do_fill(input logic [RW-1:0] rv, input logic gaps);
    for (int j = 1; j <= NL; j++) begin
      if (gaps) cyc(1'b0, 1'b1, 1'b0, 7'd9, fill(j-1), 1'b1, 1'b0);
      cyc(1'b1, gaps, 1'b0, (j == NL) ? rv : 7'(j + 20), fill(j), 1'b1, 1'b0);
    end
  endtask

  initial begin
    bus.tick = 1'b0; bus.trigger = 1'b0; bus.abort = 1'b0; bus.rnd = '0;
    #2;
    chk("rst_lights", 32'(bus.lights), 32'h0);
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_done",   32'(bus.done),   32'h0);
    chk("rst_rnd_en", 32'(bus.rnd_en), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Nominal run with stray triggers, rnd=5 at fill completion.
    cyc(1'b0, 1'b0, 1'b0, 7'd3, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 7'd3, 8'h00, 1'b1, 1'b0);
    do_fill(7'd5, 1'b1);
    for (int k = 9; k <= 12; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 7'd100, 8'hFF, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 7'd100, 8'hFF, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0, 7'd100, 8'h00, 1'b0, 1'b1);
    // Trigger one cycle after done starts a new FILL; coincident tick ignored.
    cyc(1'b1, 1'b1, 1'b0, 7'd100, 8'h00, 1'b1, 1'b0);

    // Zero random value with tick held high: exactly one HOLD tick.
    do_fill(7'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0);

    // Abort in IDLE ignored; abort with trigger accepts the trigger.
    cyc(1'b1, 1'b0, 1'b1, 7'd1, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 7'd1, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd1, 8'h01, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd1, 8'h03, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd1, 8'h07, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 7'd1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd1, 8'h00, 1'b0, 1'b0);

    // Abort in HOLD.
    cyc(1'b0, 1'b1, 1'b0, 7'd3, 8'h00, 1'b1, 1'b0);
    do_fill(7'd3, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd3, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 7'd3, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 7'd3, 8'h00, 1'b0, 1'b0);

    // Maximum random value: 127 HOLD ticks.
    cyc(1'b0, 1'b1, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0);
    do_fill(7'd127, 1'b0);
    for (int k = 1; k < 127; k++) cyc(1'b1, 1'b0, 1'b0, 7'(k), 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-HOLD.
    cyc(1'b0, 1'b1, 1'b0, 7'd50, 8'h00, 1'b1, 1'b0);
    do_fill(7'd50, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 7'd50, 8'hFF, 1'b1, 1'b0);
    bus.tick = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_lights", 32'(bus.lights), 32'h0);
    chk("arst_busy",   32'(bus.busy),   32'h0);
    chk("arst_done",   32'(bus.done),   32'h0);
    chk("arst_rnd_en", 32'(bus.rnd_en), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 7'd50, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
